operand_entry_rf: RTL and testbench
===================================

Name: operand_entry_rf

Overview:
Parametrised keypad operand register file for the calculator datapath, and the successor to the fixed two-digit, two-register block. It collects a DIGITS-long decimal entry from keypad digit codes, with clear and backspace, and drives a per-digit display bus. On commit it converts the entry from BCD to binary over several cycles and writes the result into one of NUM_REGS registers. Two registered read ports feed the ALU.

Parameters:
DIGITS, 4, max decimal digits per entry (1-8)
DATA_W, 16, register / ALU operand width
AW, 2, register address width; NUM_REGS = 2**AW

Ports:
CLK  in  1  clock, all state on posedge
RST_N  in  1  synchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  keypad code; 0-9 digit, 10-15 ignored
clr  in  1  clear entry buffer
bksp  in  1  delete newest digit
commit  in  1  start convert+write of entry
W_addr  in  AW  target register, sampled with commit
R_addr1  in  AW  read port 1 address
R_addr2  in  AW  read port 2 address
Dout_1  out  DATA_W  RF[R_addr1], registered
Dout_2  out  DATA_W  RF[R_addr2], registered
Dis  out  4*DIGITS  entry BCD, Dis[3:0] = ones digit (newest)
entry_len  out  4  digits currently held (0..DIGITS)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse on RF write
ovf  out  1  last committed value saturated

Behaviour:
- Reset (RST_N=0 at posedge) has top priority and aborts any conversion.
  - Cleared to 0: all RF entries, entry buffer, Dis, entry_len, Dout_1/2, busy, done, ovf.
  - State returns to IDLE.
- States: IDLE, CONV, WRITE.
- IDLE entry edits are priority clr > bksp > commit > digit. Only one action is taken per cycle.
  - clr: buffer=0, entry_len=0.
  - bksp: buffer shifts right one digit, top digit=0, entry_len-1. No-op when entry_len=0.
  - digit (key_valid, key_code<=9, entry_len<DIGITS): buffer shifts left one digit, new digit into Dis[3:0], entry_len+1.
  - Digit when entry_len==DIGITS: ignored, buffer unchanged.
  - key_valid with key_code>=10: ignored.
- commit in IDLE:
  - Latch W_addr.
  - Snapshot the buffer into a conversion register.
  - acc=0, digit index=DIGITS-1, go to CONV, busy=1.
  - entry_len=0 is legal and writes 0.
- CONV: each cycle acc <= acc*10 + digit[index], index-1. The most significant digit is processed first.
  - acc is wide enough to hold 10**DIGITS-1 without loss.
  - After DIGITS cycles go to WRITE.
- WRITE (one cycle), then IDLE with busy=0:
  - RF[latched addr] <= min(acc, 2**DATA_W-1).
  - ovf <= (acc > 2**DATA_W-1).
  - done=1 for exactly this cycle.
  - Entry buffer, Dis and entry_len cleared.
- Timing: commit sampled at edge 0 → busy high after edges 0..DIGITS → write plus done at edge DIGITS+1 → new value visible on Dout at edge DIGITS+2.
  - DIGITS=4: done high between edges 5 and 6.
- While busy:
  - key_valid, clr, bksp and commit are ignored, not queued.
  - Dis keeps showing the frozen entry until WRITE.
- Read ports:
  - Every posedge, Dout_n <= RF[R_addr_n] (1-cycle latency).
  - No write bypass: a read in the write cycle returns the old value.
  - Both ports may address the same register.
- ovf holds its value until the next WRITE or reset.

Test Plan:
- Reset, key 1,2,3, commit with W_addr=2 → Dis=0x0123 and entry_len=3 before commit; busy for 5 cycles; done one cycle later; R_addr1=2 gives Dout_1=123; Dis=0, ovf=0.
- Keys 4,5,6, bksp, key 7, commit W_addr=1 → RF[1]=457; clr after keys 8,9 → entry_len=0, Dis=0.
- Keys 1,2,3,4,5 → 5 ignored, Dis=0x1234; commit W_addr=0 → RF[0]=1234; keys 11 and 15 → no change.
- DIGITS=5, DATA_W=16: keys 9,9,9,9,9, commit → RF value 65535, ovf=1. Next commit of 12 → 12, ovf=0.
- During busy, press key 7, commit and clr → all ignored; stored value unchanged. Commit with empty entry → RF[W_addr]=0.
- RST_N low in the 2nd CONV cycle → busy=0, target RF stays 0, all outputs 0 next cycle.

Source files
------------

// File: rtl/operand_entry_rf.sv
// Keypad operand register file: collects a decimal entry, converts it BCD->binary
// over DIGITS cycles on commit, and stores it (saturated) into a small register file.
`timescale 1ns/1ps
module operand_entry_rf #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                clr,
    input  logic                bksp,
    input  logic                commit,
    input  logic [AW-1:0]       W_addr,
    input  logic [AW-1:0]       R_addr1,
    input  logic [AW-1:0]       R_addr2,
    output logic [DATA_W-1:0]   Dout_1,
    output logic [DATA_W-1:0]   Dout_2,
    output logic [4*DIGITS-1:0] Dis,
    output logic [3:0]          entry_len,
    output logic                busy,
    output logic                done,
    output logic                ovf
);
    localparam int unsigned NUM_REGS = 2**AW;
    localparam int unsigned BW       = 4*DIGITS;
    localparam int unsigned ACC_W    = $clog2(10**DIGITS);
    localparam int unsigned CMP_W    = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'({DATA_W{1'b1}});

    typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

    state_t              state;
    state_t              state_next;
    logic [BW-1:0]       entry;
    logic [BW-1:0]       snap;
    logic [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]    idx;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   rf [NUM_REGS];

    logic                digit_ok_c;
    logic [ACC_W-1:0]    acc_next_c;
    logic                ovf_c;
    logic [DATA_W-1:0]   wr_data_c;

    assign Dis = entry;

    // Datapath helpers: digit acceptance, MSD-first accumulate, saturation
    always_comb begin
        digit_ok_c = key_valid && (key_code <= 4'd9) && (entry_len < 4'(DIGITS));
        acc_next_c = acc * ACC_W'(10) + ACC_W'(snap[BW-1 -: 4]);
        ovf_c      = CMP_W'(acc) > MAX_VAL;
        wr_data_c  = ovf_c ? {DATA_W{1'b1}} : DATA_W'(acc);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!clr && !bksp && commit) state_next = CONV;
            CONV:    if (idx == '0) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            entry     <= '0;
            entry_len <= '0;
            snap      <= '0;
            acc       <= '0;
            idx       <= '0;
            waddr     <= '0;
            Dout_1    <= '0;
            Dout_2    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            state  <= state_next;
            busy   <= (state_next != IDLE);
            done   <= (state == WRITE);
            Dout_1 <= rf[R_addr1];
            Dout_2 <= rf[R_addr2];
            case (state)
                IDLE: begin
                    if (clr) begin
                        entry     <= '0;
                        entry_len <= '0;
                    end else if (bksp) begin
                        if (entry_len != '0) begin
                            entry     <= entry >> 4;
                            entry_len <= entry_len - 4'd1;
                        end
                    end else if (commit) begin
                        waddr <= W_addr;
                        snap  <= entry;
                        acc   <= '0;
                        idx   <= IDX_W'(DIGITS - 1);
                    end else if (digit_ok_c) begin
                        entry     <= (entry << 4) | BW'(key_code);
                        entry_len <= entry_len + 4'd1;
                    end
                end
                CONV: begin
                    acc  <= acc_next_c;
                    snap <= snap << 4;
                    idx  <= idx - IDX_W'(1);
                end
                WRITE: begin
                    rf[waddr] <= wr_data_c;
                    ovf       <= ovf_c;
                    entry     <= '0;
                    entry_len <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_entry_rf.sv
// Directed bench for operand_entry_rf (DIGITS=5, DATA_W=16): entry-edit table plus
// hand-written commit, overflow, busy-ignore and mid-conversion reset sequences.
`timescale 1ns/1ps
module tb_operand_entry_rf;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AW     = 2;

    logic                CLK;
    logic                RST_N;
    logic                key_valid;
    logic [3:0]          key_code;
    logic                clr;
    logic                bksp;
    logic                commit;
    logic [AW-1:0]       W_addr;
    logic [AW-1:0]       R_addr1;
    logic [AW-1:0]       R_addr2;
    logic [DATA_W-1:0]   Dout_1;
    logic [DATA_W-1:0]   Dout_2;
    logic [4*DIGITS-1:0] Dis;
    logic [3:0]          entry_len;
    logic                busy;
    logic                done;
    logic                ovf;

    int n_cmp = 0;
    int n_err = 0;

    operand_entry_rf #(.DIGITS(DIGITS), .DATA_W(DATA_W), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .key_valid(key_valid), .key_code(key_code),
        .clr(clr), .bksp(bksp), .commit(commit), .W_addr(W_addr),
        .R_addr1(R_addr1), .R_addr2(R_addr2), .Dout_1(Dout_1), .Dout_2(Dout_2),
        .Dis(Dis), .entry_len(entry_len), .busy(busy), .done(done), .ovf(ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        c;
        logic        b;
        logic [19:0] dis;
        logic [3:0]  len;
    } vec_t;

    vec_t tbl [20];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic read_check(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [15:0] e1, input logic [15:0] e2);
        R_addr1 = a1;
        R_addr2 = a2;
        step();
        check("rd_port1", 32'(Dout_1), 32'(e1));
        check("rd_port2", 32'(Dout_2), 32'(e2));
    endtask

    // Commit and follow the conversion; R_addr1 watches the target to show no bypass.
    task automatic do_commit(input logic [AW-1:0] a, input bit noisy,
                             input logic [15:0] old_val, input logic [15:0] new_val,
                             input logic exp_ovf);
        logic [19:0] frozen;
        int n;
        frozen  = Dis;
        R_addr1 = a;
        W_addr  = a;
        commit  = 1'b1;
        step();
        commit  = 1'b0;
        W_addr  = a ^ 2'b11;
        check("busy_start", 32'(busy), 32'd1);
        if (noisy) begin
            key_valid = 1'b1; key_code = 4'd7; clr = 1'b1; bksp = 1'b1; commit = 1'b1;
        end
        n = 0;
        while (!done && n < 20) begin
            if (noisy) check("dis_frozen", 32'(Dis), 32'(frozen));
            step();
            n++;
            if (!done) check("busy_hold", 32'(busy), 32'd1);
        end
        key_valid = 1'b0; clr = 1'b0; bksp = 1'b0; commit = 1'b0;
        check("done_latency", 32'(n), 32'(DIGITS + 1));
        check("busy_end", 32'(busy), 32'd0);
        check("dis_cleared", 32'(Dis), 32'd0);
        check("len_cleared", 32'(entry_len), 32'd0);
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("no_bypass", 32'(Dout_1), 32'(old_val));
        step();
        check("done_pulse", 32'(done), 32'd0);
        check("not_requeued", 32'(busy), 32'd0);
        check("new_value", 32'(Dout_1), 32'(new_val));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 20'h00001, 4'd1};
        tbl[1]  = '{1'b1, 4'd2,  1'b0, 1'b0, 20'h00012, 4'd2};
        tbl[2]  = '{1'b1, 4'd3,  1'b0, 1'b0, 20'h00123, 4'd3};
        tbl[3]  = '{1'b1, 4'd11, 1'b0, 1'b0, 20'h00123, 4'd3};
        tbl[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 20'h00012, 4'd2};
        tbl[5]  = '{1'b1, 4'd7,  1'b0, 1'b0, 20'h00127, 4'd3};
        tbl[6]  = '{1'b1, 4'd5,  1'b0, 1'b1, 20'h00012, 4'd2};
        tbl[7]  = '{1'b1, 4'd4,  1'b1, 1'b1, 20'h00000, 4'd0};
        tbl[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 20'h00000, 4'd0};
        tbl[9]  = '{1'b1, 4'd9,  1'b0, 1'b0, 20'h00009, 4'd1};
        tbl[10] = '{1'b1, 4'd8,  1'b0, 1'b0, 20'h00098, 4'd2};
        tbl[11] = '{1'b1, 4'd7,  1'b0, 1'b0, 20'h00987, 4'd3};
        tbl[12] = '{1'b1, 4'd6,  1'b0, 1'b0, 20'h09876, 4'd4};
        tbl[13] = '{1'b1, 4'd5,  1'b0, 1'b0, 20'h98765, 4'd5};
        tbl[14] = '{1'b1, 4'd4,  1'b0, 1'b0, 20'h98765, 4'd5};
        tbl[15] = '{1'b1, 4'd15, 1'b0, 1'b0, 20'h98765, 4'd5};
        tbl[16] = '{1'b0, 4'd0,  1'b0, 1'b1, 20'h09876, 4'd4};
        tbl[17] = '{1'b1, 4'd0,  1'b0, 1'b0, 20'h98760, 4'd5};
        tbl[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 20'h00000, 4'd0};
        tbl[19] = '{1'b0, 4'd3,  1'b0, 1'b0, 20'h00000, 4'd0};

        RST_N = 1'b0; key_valid = 1'b0; key_code = '0; clr = 1'b0; bksp = 1'b0;
        commit = 1'b0; W_addr = '0; R_addr1 = '0; R_addr2 = '0;
        step();
        step();
        check("rst_dout1", 32'(Dout_1), 32'd0);
        check("rst_dout2", 32'(Dout_2), 32'd0);
        check("rst_dis", 32'(Dis), 32'd0);
        check("rst_len", 32'(entry_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        RST_N = 1'b1;
        step();

        // Entry editing table
        for (int i = 0; i < 20; i++) begin
            key_valid = tbl[i].kv; key_code = tbl[i].code; clr = tbl[i].c; bksp = tbl[i].b;
            step();
            key_valid = 1'b0; clr = 1'b0; bksp = 1'b0;
            check($sformatf("tbl%0d_dis", i), 32'(Dis), 32'(tbl[i].dis));
            check($sformatf("tbl%0d_len", i), 32'(entry_len), 32'(tbl[i].len));
        end

        press(4'd1); press(4'd2); press(4'd3);
        check("pre_commit_dis", 32'(Dis), 32'h00123);
        check("pre_commit_len", 32'(entry_len), 32'd3);
        do_commit(2'd2, 1'b0, 16'd0, 16'd123, 1'b0);

        press(4'd4); press(4'd5); press(4'd6);
        bksp = 1'b1; step(); bksp = 1'b0;
        press(4'd7);
        check("bksp_dis", 32'(Dis), 32'h00457);
        do_commit(2'd1, 1'b0, 16'd0, 16'd457, 1'b0);
        read_check(2'd1, 2'd2, 16'd457, 16'd123);

        press(4'd8); press(4'd9);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_len", 32'(entry_len), 32'd0);
        check("clr_dis", 32'(Dis), 32'd0);

        for (int k = 1; k <= 6; k++) press(4'(k));
        check("full_dis", 32'(Dis), 32'h12345);
        press(4'd11); press(4'd15);
        check("ignored_dis", 32'(Dis), 32'h12345);
        do_commit(2'd0, 1'b0, 16'd0, 16'd12345, 1'b0);
        read_check(2'd0, 2'd0, 16'd12345, 16'd12345);

        for (int k = 0; k < 5; k++) press(4'd9);
        do_commit(2'd3, 1'b0, 16'd0, 16'hFFFF, 1'b1);
        press(4'd1); press(4'd2);
        check("ovf_held", 32'(ovf), 32'd1);
        do_commit(2'd3, 1'b0, 16'hFFFF, 16'd12, 1'b0);

        press(4'd3);
        do_commit(2'd1, 1'b1, 16'd457, 16'd3, 1'b0);
        check("post_noise_len", 32'(entry_len), 32'd0);

        do_commit(2'd2, 1'b0, 16'd123, 16'd0, 1'b0);
        read_check(2'd3, 2'd1, 16'd12, 16'd3);

        for (int k = 0; k < 5; k++) press(4'd9);
        do_commit(2'd0, 1'b0, 16'd12345, 16'hFFFF, 1'b1);

        // Reset during the second conversion cycle
        press(4'd4); press(4'd4);
        R_addr1 = 2'd1; R_addr2 = 2'd3;
        W_addr = 2'd1; commit = 1'b1; step(); commit = 1'b0;
        step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dis", 32'(Dis), 32'd0);
        check("abort_len", 32'(entry_len), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_dout1", 32'(Dout_1), 32'd0);
        check("abort_dout2", 32'(Dout_2), 32'd0);
        for (int k = 0; k < DIGITS + 3; k++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_idle", 32'(busy), 32'd0);
        read_check(2'd1, 2'd0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
